// File: rtl/scancode_decoder_pkg.sv
// Shared constants, event type and scan-code-to-ASCII map for the PS/2
// set-2 scan-code decoder.
package scancode_decoder_pkg;

  localparam int CODE_W  = 8;
  localparam int ASCII_W = 8;

  // Prefix bytes
  localparam logic [CODE_W-1:0] PFX_E0 = 8'hE0;
  localparam logic [CODE_W-1:0] PFX_F0 = 8'hF0;

  // Modifier base codes (only meaningful when not extended)
  localparam logic [CODE_W-1:0] KEY_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] KEY_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] KEY_CAPS   = 8'h58;

  // Controller/keyboard status bytes that never belong to a key
  localparam int NUM_IGNORED = 6;
  localparam logic [NUM_IGNORED-1:0][CODE_W-1:0] IGNORED_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_state_t;

  typedef struct packed {
    logic [CODE_W-1:0]  code;
    logic               ext;
    logic               rel;
    logic [ASCII_W-1:0] ascii;
  } key_ev_t;

  localparam int EV_W = $bits(key_ev_t);

  function automatic logic is_ignored(input logic [CODE_W-1:0] c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_IGNORED; i++)
      if (c == IGNORED_CODES[i]) hit = 1'b1;
    return hit;
  endfunction

  // shift selects digit symbols; upper (shift XOR caps) selects letter case.
  // Extended keys have no printable mapping.
  function automatic logic [ASCII_W-1:0] scan_to_ascii(
    input logic [CODE_W-1:0] c,
    input logic              ext,
    input logic              shift,
    input logic              upper
  );
    logic [ASCII_W-1:0] a;
    logic               letter;
    a      = 8'h00;
    letter = 1'b1;
    case (c)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      default: begin
        letter = 1'b0;
        case (c)
          8'h16: a = shift ? "!" : "1";
          8'h1E: a = shift ? "@" : "2";
          8'h26: a = shift ? "#" : "3";
          8'h25: a = shift ? "$" : "4";
          8'h2E: a = shift ? "%" : "5";
          8'h36: a = shift ? "^" : "6";
          8'h3D: a = shift ? "&" : "7";
          8'h3E: a = shift ? "*" : "8";
          8'h46: a = shift ? "(" : "9";
          8'h45: a = shift ? ")" : "0";
          8'h29: a = 8'h20;
          8'h5A: a = 8'h0D;
          8'h66: a = 8'h08;
          8'h76: a = 8'h1B;
          default: a = 8'h00;
        endcase
      end
    endcase
    if (letter && upper) a = a - 8'h20;
    if (ext) a = 8'h00;
    return a;
  endfunction

endpackage

// File: rtl/scancode_decoder_fifo.sv
// Show-ahead synchronous FIFO with sticky overflow. Head entry is visible on
// rd_data whenever empty=0; a pop on a full FIFO frees room for a same-cycle
// push, a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, do_rd, do_wr;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !do_wr) overflow <= 1'b1;
    end
  end

  // Storage has no reset; only entries behind count are ever observed
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/scancode_decoder.sv
// PS/2 set-2 scan-code decoder: prefix parser, modifier tracking, ASCII map
// and a show-ahead event FIFO.
module scancode_decoder
  import scancode_decoder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               code_valid,
  input  logic               rd_en,
  output logic               empty,
  output logic [CODE_W-1:0]  ev_code,
  output logic               ev_ext,
  output logic               ev_release,
  output logic [ASCII_W-1:0] ev_ascii,
  output logic               overflow
);

  parse_state_t state;
  logic         shift_l, shift_r, caps_on, caps_held;
  logic         vld_pipe;
  key_ev_t      push_ev, head_ev;
  logic         cur_ext, cur_rel, is_mod;
  logic [ASCII_W-1:0] cur_ascii;

  assign cur_ext   = (state == EXT) || (state == EXT_BRK);
  assign cur_rel   = (state == BRK) || (state == EXT_BRK);
  assign is_mod    = !cur_ext && (code_in == KEY_LSHIFT || code_in == KEY_RSHIFT ||
                                  code_in == KEY_CAPS);
  // Uses modifier state as it stands before this byte takes effect
  assign cur_ascii = scan_to_ascii(code_in, cur_ext, shift_l | shift_r,
                                   (shift_l | shift_r) ^ caps_on);

  // Parser FSM, modifier state and registered event push (one cycle to FIFO)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_on   <= 1'b0;
      caps_held <= 1'b0;
      vld_pipe  <= 1'b0;
      push_ev   <= '0;
    end else begin
      vld_pipe <= 1'b0;
      if (code_valid) begin
        if (is_ignored(code_in)) begin
          state <= IDLE;
        end else if (code_in == PFX_E0 && state != BRK) begin
          state <= (state == EXT_BRK) ? EXT_BRK : EXT;
        end else if (code_in == PFX_F0) begin
          state <= cur_ext ? EXT_BRK : BRK;
        end else begin
          state <= IDLE;
          if (is_mod) begin
            if (code_in == KEY_LSHIFT) shift_l <= !cur_rel;
            if (code_in == KEY_RSHIFT) shift_r <= !cur_rel;
            if (code_in == KEY_CAPS) begin
              if (!cur_rel && !caps_held) caps_on <= !caps_on;
              caps_held <= !cur_rel;
            end
          end else begin
            vld_pipe <= 1'b1;
            push_ev  <= '{code: code_in, ext: cur_ext, rel: cur_rel, ascii: cur_ascii};
          end
        end
      end
    end
  end

  sync_fifo #(.WIDTH(EV_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld_pipe),
    .wr_data  (push_ev),
    .rd_en    (rd_en),
    .rd_data  (head_ev),
    .empty    (empty),
    .overflow (overflow)
  );

  assign ev_code    = head_ev.code;
  assign ev_ext     = head_ev.ext;
  assign ev_release = head_ev.rel;
  assign ev_ascii   = head_ev.ascii;

endmodule

// File: tb/tb_scancode_decoder.sv
// Scoreboard bench for scancode_decoder: stimulus pushes expected events,
// a monitor pops and compares whenever the FIFO presents a head entry.
module tb_scancode_decoder;
  import scancode_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic       rd_en;
  logic       empty, ev_ext, ev_release, overflow;
  logic [7:0] ev_code, ev_ascii;

  logic mon_rd = 1'b0, stim_rd = 1'b0, mon_en = 1'b1;
  assign rd_en = mon_rd | stim_rd;

  int tests = 0, fails = 0;
  key_ev_t exp_q[$];

  always #5 clk = ~clk;

  scancode_decoder #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .rd_en(rd_en), .empty(empty), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_release(ev_release), .ev_ascii(ev_ascii), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic key_ev_t mk(input logic [7:0] c, input logic e, input logic r,
                                 input logic [7:0] a);
    key_ev_t ev;
    ev = '{code: c, ext: e, rel: r, ascii: a};
    return ev;
  endfunction

  // Monitor: compare head against scoreboard and pop it
  initial begin
    key_ev_t got, want;
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (mon_en && !empty) begin
        got = mk(ev_code, ev_ext, ev_release, ev_ascii);
        if (exp_q.size() == 0) begin
          check("unexpected_event", got, 32'h0);
          tests--; // counted as a failure above only if it differs; force one
          tests++;
          if (got === 32'h0) begin fails++; $display("FAIL unexpected_event: got %0h expected none", got); end
        end else begin
          want = exp_q.pop_front();
          check("event", got, want);
        end
        mon_rd = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_in    = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, exp_q.size() == 0 && empty}, 32'd1);
  endtask

  initial begin
    key_ev_t head;
    do_reset();
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_overflow", {31'd0, overflow}, 32'd0);

    // single make
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    send(8'h1C);
    drain("drain_single");

    // shift make/break around a letter
    send(8'h12);
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h41));
    send(8'h1C);
    send(8'hF0); send(8'h12);
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    send(8'h1C);
    drain("drain_shift");

    // caps toggles once per press cycle
    send(8'h58); send(8'hF0); send(8'h58); send(8'h58);
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    send(8'h1C);
    send(8'hF0); send(8'h58);
    send(8'h58); send(8'hF0); send(8'h58);
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h41));
    send(8'h1C);
    drain("drain_caps");
    do_reset();

    // extended make and break
    send(8'hE0);
    exp_q.push_back(mk(8'h75, 1, 0, 8'h00));
    send(8'h75);
    send(8'hE0); send(8'hF0);
    exp_q.push_back(mk(8'h75, 1, 1, 8'h00));
    send(8'h75);
    drain("drain_ext");

    // digits with/without shift, space, enter, release, unmapped, ext shift
    send(8'h12);
    exp_q.push_back(mk(8'h16, 0, 0, 8'h21)); send(8'h16);
    send(8'hF0); send(8'h12);
    exp_q.push_back(mk(8'h16, 0, 0, 8'h31)); send(8'h16);
    exp_q.push_back(mk(8'h29, 0, 0, 8'h20)); send(8'h29);
    exp_q.push_back(mk(8'h5A, 0, 0, 8'h0D)); send(8'h5A);
    send(8'hF0);
    exp_q.push_back(mk(8'h1C, 0, 1, 8'h61)); send(8'h1C);
    exp_q.push_back(mk(8'h05, 0, 0, 8'h00)); send(8'h05);
    send(8'hE0);
    exp_q.push_back(mk(8'h12, 1, 0, 8'h00)); send(8'h12);
    // ignored byte discards prefix and leaves shift untouched
    send(8'hE0); send(8'hAA);
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61)); send(8'h1C);
    drain("drain_misc");

    // overflow: nine makes with no reads
    mon_en = 1'b0;
    repeat (9) send(8'h1C);
    repeat (8) exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    repeat (3) @(negedge clk);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("full_not_empty", {31'd0, empty}, 32'd0);
    // push and pop in the same cycle while full
    head = mk(ev_code, ev_ext, ev_release, ev_ascii);
    check("full_head", head, exp_q.pop_front());
    @(negedge clk);
    code_in = 8'h32; code_valid = 1'b1;
    exp_q.push_back(mk(8'h32, 0, 0, 8'h62));
    @(negedge clk);
    code_valid = 1'b0; stim_rd = 1'b1;
    @(negedge clk);
    stim_rd = 1'b0;
    mon_en = 1'b1;
    drain("drain_overflow");
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // reset mid-prefix discards the prefix and clears state
    send(8'hE0);
    do_reset();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    send(8'h1C);
    drain("drain_after_rst");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scancode_decoder.md
SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have port: code_in  in  8  PS/2 set-2 scan-code byte from the receive stage.
REQ-004 SHALL have port: code_valid  in  1  one-cycle strobe; code_in valid when high.
REQ-005 SHALL have port: rd_en  in  1  pop head event; ignored when empty=1.
REQ-006 SHALL have port: empty  out  1  event FIFO empty.
REQ-007 SHALL have port: ev_code  out  8  head event base scan code.
REQ-008 SHALL have port: ev_ext  out  1  head event preceded by E0.
REQ-009 SHALL have port: ev_release  out  1  head event is a break (F0).
REQ-010 SHALL have port: ev_ascii  out  8  head event ASCII; 0x00 if unmapped.
REQ-011 SHALL have port: overflow  out  1  sticky; an event was dropped.
REQ-012 SHALL have parameter: DEPTH, default 8, FIFO entries (power of two).

Function
REQ-013 Parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK; it advances only on cycles with code_valid=1.
REQ-014 Transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; EXT+E0->EXT; BRK+F0->BRK; EXT_BRK+E0/F0->EXT_BRK.
REQ-015 Any other byte in any state SHALL complete a key (ext = state in {EXT,EXT_BRK}; release = state in {BRK,EXT_BRK}); FSM SHALL return to IDLE.
REQ-016 Bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF SHALL be discarded and the FSM SHALL return to IDLE.
REQ-017 Non-extended 0x12/0x59 (shift) SHALL set/clear shift_l/shift_r on make/break; no event pushed.
REQ-018 Non-extended 0x58 (caps) make SHALL toggle caps_on only while caps_held=0, then set caps_held; break clears caps_held; no event pushed.
REQ-019 Every other completed key, make or release, repeated makes included, SHALL push one event {code, ext, release, ascii}.
REQ-020 ASCII: letters 0x61-0x7A, uppercase 0x41-0x5A when (shift_l|shift_r) XOR caps_on; digits 0x30-0x39, shifted to US symbols !@#$%^&*(); space 0x20, enter 0x0D, backspace 0x08, esc 0x1B; all extended keys and unlisted codes 0x00.
REQ-021 ASCII SHALL use modifier state before the completing byte.
REQ-022 Latency: byte completing a key sampled at edge N; event written at edge N+1; empty=0 from after edge N+1.
REQ-023 FIFO SHALL be show-ahead: ev_* show head entry whenever empty=0; rd_en=1 pops at the clock edge.
REQ-024 Push while full with no pop SHALL drop the new event and set overflow; push and pop in one cycle while full SHALL both succeed.
REQ-025 Pop and push in one cycle while empty SHALL write only; the new entry is visible next cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-027 ev_* SHALL be don't-care while empty=1.

Reset
REQ-028 On rst=1 at a clock edge: FSM->IDLE, FIFO emptied (empty=1), overflow=0, shift_l/shift_r/caps_on/caps_held=0.
REQ-029 rst SHALL override code_valid and rd_en in the same cycle; a partial E0/F0 prefix SHALL be discarded.

Structure
REQ-030 Shared package SHALL hold prefix constants E0/F0, modifier codes 0x12/0x59/0x58, ignored-code list, event field widths, and the scan-code-to-ASCII function.
REQ-031 The FIFO SHALL be one sub-module, sync_fifo (parameterised width/depth, show-ahead); parser, modifiers and ASCII map SHALL live in scancode_decoder.

Verification
REQ-032 Byte 0x1C -> one event {1C, ext0, rel0, 0x61}.
REQ-033 Bytes 12,1C,F0,12,1C -> events {1C,0,0,0x41} then {1C,0,0,0x61}.
REQ-034 Bytes 58,F0,58,58,1C -> caps toggles once per press cycle: caps_on=0 after second 58 make; event ascii 0x61; 58,F0,58,1C gives 0x41.
REQ-035 Bytes E0,75,E0,F0,75 -> {75,1,0,00} then {75,1,1,00}.
REQ-036 Nine makes of 0x1C with rd_en=0 -> 8 entries, overflow=1; then push+pop on one cycle keeps count 8.
REQ-037 E0, rst pulse, then 1C -> event {1C,0,0,0x61}; FIFO empty and overflow=0 right after reset.
